hazard_stall_ctrl: RTL and testbench

Stall/flush controller for the 5-stage pipeline. It watches the instruction in ID and the one in EX, and drives the enable of the PC register and the IF/ID register plus the flush (bubble insert) of the ID/EX register. It handles two stall causes: load-use hazards, and HI/LO access while the multiply/divide unit is busy. A multi-cycle busy counter tracks the multiply/divide unit.

---
 rtl/pipe_defs.sv | 27 ++
 rtl/mdu_busy_counter.sv | 46 ++++
 rtl/hazard_stall_ctrl.sv | 97 +++++++++
 tb/tb_hazard_stall_ctrl.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/pipe_defs.sv
// Shared pipeline definitions for the hazard/stall control slice.
// Contents:
//   REG_ZERO                  - architectural zero register index
//   MULT_CYCLES_DEF           - default MDU busy cycles after a mult/multu
//   DIV_CYCLES_DEF            - default MDU busy cycles after a div/divu
//   MDU_CNT_W                 - width of the MDU busy counter
//   mdu_state_e               - MDU counter state (idle when count is zero)
//   mdu_load_val()            - reload value for a newly issued MDU operation
package pipe_defs;

  localparam logic [4:0]  REG_ZERO        = 5'd0;
  localparam int unsigned MULT_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF  = 10;
  localparam int unsigned MDU_CNT_W       = 4;

  typedef enum logic {
    MduIdle,
    MduBusy
  } mdu_state_e;

  function automatic logic [MDU_CNT_W-1:0] mdu_load_val(input logic        is_div,
                                                        input int unsigned mult_c,
                                                        input int unsigned div_c);
    return is_div ? MDU_CNT_W'(div_c) : MDU_CNT_W'(mult_c);
  endfunction

endpackage

// File: rtl/mdu_busy_counter.sv
// Multi-cycle busy tracker for the multiply/divide unit.
// A 4-bit down-counter: idle at zero, loaded with the operation latency when an
// MDU operation issues in EX, then counts down to zero.
// Ports:
//   clk    - pipeline clock, rising edge
//   reset  - synchronous, active-low
//   start  - MDU operation issuing in EX this cycle
//   is_div - qualifies start: 1 = div/divu, 0 = mult/multu
//   busy   - MDU result not yet valid (depends on the counter register only)
module mdu_busy_counter
  import pipe_defs::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic is_div,
  output logic busy
);

  logic [MDU_CNT_W-1:0] r_cnt;
  mdu_state_e           w_state;

  always_comb begin
    w_state = (r_cnt == '0) ? MduIdle : MduBusy;
  end

  // A start while busy is dropped: the ID-stage MDU stall keeps a second MDU
  // op from reaching EX until the counter has drained.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cnt <= '0;
    end else begin
      unique case (w_state)
        MduIdle: if (start) r_cnt <= mdu_load_val(is_div, MULT_CYCLES, DIV_CYCLES);
        MduBusy: r_cnt <= r_cnt - MDU_CNT_W'(1);
        default: r_cnt <= '0;
      endcase
    end
  end

  assign busy = (r_cnt != '0);

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Stall/flush controller for the 5-stage pipeline.
// Detects load-use hazards between ID and EX and, when HAZARD_MDU_STALL_EN is
// defined, HI/LO access in ID while the multiply/divide unit is busy or issuing.
// A stall freezes PC and IF/ID and bubbles ID/EX in the same cycle.
// Configuration macro: HAZARD_MDU_STALL_EN (undefined: load-use stalls only,
// MDU inputs ignored, mdu_busy tied low).
// Ports:
//   clk, reset      - clock (rising edge), synchronous active-low reset
//   id_rs, id_rt    - source register fields of the ID instruction
//   id_use_rs/rt    - ID instruction actually reads rs/rt
//   id_is_mdu       - ID instruction is mult/div/mfhi/mflo/mthi/mtlo
//   ex_rd           - destination register of the EX instruction
//   ex_is_load      - EX instruction is a load
//   ex_mdu_start    - EX instruction is mult/multu/div/divu
//   ex_mdu_is_div   - qualifies ex_mdu_start: 1 = div, 0 = mult
//   pc_en           - PC register write enable
//   if_id_en        - IF/ID register enable
//   id_ex_flush     - clear ID/EX to a nop on the next edge
//   mdu_busy        - MDU result not yet valid
//   stall_cnt       - saturating count of stalled cycles
module hazard_stall_ctrl
  import pipe_defs::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_use_rs,
  input  logic        id_use_rt,
  input  logic        id_is_mdu,
  input  logic [4:0]  ex_rd,
  input  logic        ex_is_load,
  input  logic        ex_mdu_start,
  input  logic        ex_mdu_is_div,
  output logic        pc_en,
  output logic        if_id_en,
  output logic        id_ex_flush,
  output logic        mdu_busy,
  output logic [15:0] stall_cnt
);

  logic        w_load_use;
  logic        w_mdu_hazard;
  logic        w_stall;
  logic        w_stall_act;
  logic [15:0] r_stall_cnt;

  assign w_load_use = ex_is_load && (ex_rd != REG_ZERO) &&
                      ((id_use_rs && (id_rs == ex_rd)) || (id_use_rt && (id_rt == ex_rd)));

`ifdef HAZARD_MDU_STALL_EN
  mdu_busy_counter #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES)
  ) u_mdu_busy_counter (
    .clk    (clk),
    .reset  (reset),
    .start  (ex_mdu_start),
    .is_div (ex_mdu_is_div),
    .busy   (mdu_busy)
  );

  // ex_mdu_start covers the issue cycle, before mdu_busy has risen.
  assign w_mdu_hazard = id_is_mdu && (mdu_busy || ex_mdu_start);
`else
  logic w_unused;
  assign w_unused     = ^{id_is_mdu, ex_mdu_start, ex_mdu_is_div,
                          MDU_CNT_W'(MULT_CYCLES), MDU_CNT_W'(DIV_CYCLES)};
  assign mdu_busy     = 1'b0;
  assign w_mdu_hazard = 1'b0;
`endif

  assign w_stall = w_load_use || w_mdu_hazard;

  // Outputs pass through while reset is held low.
  assign w_stall_act = reset && w_stall;

  always_comb begin
    pc_en       = !w_stall_act;
    if_id_en    = !w_stall_act;
    id_ex_flush = w_stall_act;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl: directed scenarios plus random
// stimulus, all checked every cycle against a behavioural model that tracks the
// MDU as "cycles remaining" and the stall count as a saturating integer.
module tb_hazard_stall_ctrl;

  localparam int unsigned MultC = 5;
  localparam int unsigned DivC  = 10;
`ifdef HAZARD_MDU_STALL_EN
  localparam bit MduEn = 1'b1;
`else
  localparam bit MduEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  id_rs, id_rt, ex_rd;
  logic        id_use_rs, id_use_rt, id_is_mdu;
  logic        ex_is_load, ex_mdu_start, ex_mdu_is_div;
  logic        pc_en, if_id_en, id_ex_flush, mdu_busy;
  logic [15:0] stall_cnt;

  always #5 clk = ~clk;

  hazard_stall_ctrl #(
    .MULT_CYCLES (MultC),
    .DIV_CYCLES  (DivC)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .id_rs         (id_rs),
    .id_rt         (id_rt),
    .id_use_rs     (id_use_rs),
    .id_use_rt     (id_use_rt),
    .id_is_mdu     (id_is_mdu),
    .ex_rd         (ex_rd),
    .ex_is_load    (ex_is_load),
    .ex_mdu_start  (ex_mdu_start),
    .ex_mdu_is_div (ex_mdu_is_div),
    .pc_en         (pc_en),
    .if_id_en      (if_id_en),
    .id_ex_flush   (id_ex_flush),
    .mdu_busy      (mdu_busy),
    .stall_cnt     (stall_cnt)
  );

  int n_total = 0;
  int n_bad   = 0;
  int m_rem   = 0;  // model: MDU cycles still to run
  int m_cnt   = 0;  // model: stalled cycles seen, saturating at 65535

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic clear_inputs();
    id_rs = 5'd0; id_rt = 5'd0; ex_rd = 5'd0;
    id_use_rs = 1'b0; id_use_rt = 1'b0; id_is_mdu = 1'b0;
    ex_is_load = 1'b0; ex_mdu_start = 1'b0; ex_mdu_is_div = 1'b0;
  endtask

  // Called just after a rising edge with inputs already driven; checks at the
  // falling edge, then advances the model across the next rising edge.
  task automatic cycle();
    bit lu, mh, st;
    @(negedge clk);
    lu = ex_is_load && (ex_rd != 0) &&
         ((id_use_rs && id_rs == ex_rd) || (id_use_rt && id_rt == ex_rd));
    mh = MduEn && id_is_mdu && ((m_rem > 0) || ex_mdu_start);
    st = reset && (lu || mh);
    check_eq("pc_en",       32'(pc_en),       32'(!st));
    check_eq("if_id_en",    32'(if_id_en),    32'(!st));
    check_eq("id_ex_flush", 32'(id_ex_flush), 32'(st));
    check_eq("mdu_busy",    32'(mdu_busy),    32'(m_rem > 0));
    check_eq("stall_cnt",   32'(stall_cnt),   32'(m_cnt));
    if (!reset) begin
      m_rem = 0;
      m_cnt = 0;
    end else begin
      if (st && m_cnt < 65535) m_cnt++;
      if (m_rem > 0) m_rem--;
      else if (MduEn && ex_mdu_start) m_rem = ex_mdu_is_div ? int'(DivC) : int'(MultC);
    end
    @(posedge clk);
    #1;
  endtask

  logic [15:0] base;

  initial begin
    clear_inputs();
    reset = 1'b0;
    @(posedge clk);
    #1;
    m_rem = 0;
    m_cnt = 0;

    // Reset held with a load-use pattern present: outputs must pass through.
    ex_is_load = 1'b1; ex_rd = 5'd8; id_rs = 5'd8; id_use_rs = 1'b1;
    cycle();
    reset = 1'b1;
    clear_inputs();
    cycle();

    // Load-use on rs: one stall cycle, then the load has left EX.
    ex_is_load = 1'b1; ex_rd = 5'd8; id_rs = 5'd8; id_use_rs = 1'b1;
    cycle();
    clear_inputs();
    cycle();
    check_eq("lu_rs_count", 32'(stall_cnt), 32'd1);

    // Load-use on rt.
    ex_is_load = 1'b1; ex_rd = 5'd17; id_rt = 5'd17; id_use_rt = 1'b1;
    cycle();
    clear_inputs();

    // Zero register never stalls.
    ex_is_load = 1'b1; ex_rd = 5'd0; id_rs = 5'd0; id_use_rs = 1'b1;
    id_rt = 5'd0; id_use_rt = 1'b1;
    cycle();
    clear_inputs();

    // Matching but unused operand.
    ex_is_load = 1'b1; ex_rd = 5'd9; id_rt = 5'd9; id_use_rt = 1'b0;
    cycle();
    clear_inputs();

    // Mult then dependent mflo held in ID.
    base = stall_cnt;
    id_is_mdu = 1'b1; ex_mdu_start = 1'b1; ex_mdu_is_div = 1'b0;
    cycle();
    ex_mdu_start = 1'b0;
    repeat (8) cycle();
    check_eq("mult_stalls", 32'(stall_cnt - base), MduEn ? 32'd6 : 32'd0);
    clear_inputs();

    // Simultaneous load-use and MDU hazard count once.
    ex_is_load = 1'b1; ex_rd = 5'd3; id_rs = 5'd3; id_use_rs = 1'b1;
    id_is_mdu = 1'b1; ex_mdu_start = 1'b1; ex_mdu_is_div = 1'b0;
    cycle();
    clear_inputs();
    repeat (7) cycle();

    // Div with reset asserted mid-busy.
    id_is_mdu = 1'b1; ex_mdu_start = 1'b1; ex_mdu_is_div = 1'b1;
    cycle();
    ex_mdu_start = 1'b0;
    repeat (3) cycle();
    reset = 1'b0;
    cycle();
    reset = 1'b1;
    cycle();
    check_eq("div_abort_busy", 32'(mdu_busy), 32'd0);
    clear_inputs();
    cycle();

    // Random traffic with small register numbers to provoke matches.
    for (int i = 0; i < 800; i++) begin
      id_rs         = 5'($urandom_range(0, 3));
      id_rt         = 5'($urandom_range(0, 3));
      ex_rd         = 5'($urandom_range(0, 3));
      id_use_rs     = 1'($urandom);
      id_use_rt     = 1'($urandom);
      ex_is_load    = 1'($urandom);
      id_is_mdu     = ($urandom_range(0, 3) == 0);
      ex_mdu_start  = ($urandom_range(0, 7) == 0);
      ex_mdu_is_div = 1'($urandom);
      reset         = ($urandom_range(0, 63) != 0);
      cycle();
    end
    reset = 1'b1;
    clear_inputs();
    repeat (12) cycle();

    // Saturation: persistent load-use for 70000 cycles.
    ex_is_load = 1'b1; ex_rd = 5'd8; id_rs = 5'd8; id_use_rs = 1'b1;
    repeat (70000) cycle();
    check_eq("saturate", 32'(stall_cnt), 32'h0000FFFF);
    clear_inputs();
    cycle();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
